// File: rtl/y86_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : y86_mem_stage
//  Purpose  : Y86-64 memory-access stage. Takes one instruction from execute,
//             classifies it as load / store / no access, runs a valid/ready
//             data-memory transaction with a wait timeout, and returns valM
//             and the instruction status with a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module y86_mem_stage #(
    parameter logic [63:0] MEM_SIZE       = 64'h10000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  icode_i,
    input  logic [63:0] valE_i,
    input  logic [63:0] valA_i,
    input  logic [63:0] valP_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] valM_o,
    output logic [3:0]  stat_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic [63:0] mem_rdata_i,
    input  logic        mem_err_i
);

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] ICMOVQ  = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Status codes
    localparam logic [3:0] SAOK = 4'd1;
    localparam logic [3:0] SHLT = 4'd2;
    localparam logic [3:0] SADR = 4'd3;
    localparam logic [3:0] SINS = 4'd4;

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Wait counter only needs to reach TIMEOUT_CYCLES-1: the timeout fires on
    // the REQ cycle in which the count would become TIMEOUT_CYCLES.
    localparam int               CNT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] wait_q,   wait_d;
    logic             req_q,    req_d;
    logic             we_q,     we_d;
    logic [63:0]      addr_q,   addr_d;
    logic [63:0]      wdata_q,  wdata_d;
    logic [63:0]      valM_q,   valM_d;
    logic [3:0]       stat_q,   stat_d;

    logic             w_access;
    logic             w_write;
    logic [63:0]      w_addr;
    logic [63:0]      w_wdata;
    logic [3:0]       w_noacc_stat;
    logic [64:0]      w_addr_end;
    logic             w_range_bad;

    // Decode the incoming instruction into access kind, address and data
    always_comb begin
        w_access     = 1'b0;
        w_write      = 1'b0;
        w_addr       = valE_i;
        w_wdata      = valA_i;
        w_noacc_stat = SAOK;
        case (icode_i)
            IRMMOVQ, IPUSHQ: begin
                w_access = 1'b1;
                w_write  = 1'b1;
            end
            ICALL: begin
                w_access = 1'b1;
                w_write  = 1'b1;
                w_wdata  = valP_i;
            end
            IMRMOVQ: begin
                w_access = 1'b1;
            end
            IPOPQ, IRET: begin
                w_access = 1'b1;
                w_addr   = valA_i;
            end
            INOP, ICMOVQ, IIRMOVQ, IOPQ, IJXX: begin
                w_noacc_stat = SAOK;
            end
            IHALT: begin
                w_noacc_stat = SHLT;
            end
            default: begin
                w_noacc_stat = SINS;
            end
        endcase
    end

    // 65-bit end address: catches both addr+8 > MEM_SIZE and 64-bit wrap
    assign w_addr_end  = {1'b0, w_addr} + 65'd8;
    assign w_range_bad = (w_addr_end > {1'b0, MEM_SIZE});

    // Next-state and datapath update for the IDLE / REQ / DONE sequence
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        valM_d  = valM_q;
        stat_d  = stat_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (!w_access) begin
                        state_d = ST_DONE;
                        stat_d  = w_noacc_stat;
                        valM_d  = 64'd0;
                    end else if (w_range_bad) begin
                        state_d = ST_DONE;
                        stat_d  = SADR;
                        valM_d  = 64'd0;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        we_d    = w_write;
                        addr_d  = w_addr;
                        wdata_d = w_wdata;
                        wait_d  = '0;
                    end
                end
            end
            ST_REQ: begin
                // Ready takes priority over a timeout landing in the same cycle
                if (mem_ready_i) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    wait_d  = '0;
                    stat_d  = mem_err_i ? SADR : SAOK;
                    valM_d  = (!we_q && !mem_err_i) ? mem_rdata_i : 64'd0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    wait_d  = '0;
                    stat_d  = SADR;
                    valM_d  = 64'd0;
                end else begin
                    wait_d  = wait_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                wait_d  = '0;
            end
        endcase
    end

    // State registers; asynchronous reset abandons any in-flight request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            valM_q  <= 64'd0;
            stat_q  <= SAOK;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valM_q  <= valM_d;
            stat_q  <= stat_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign valM_o      = valM_q;
    assign stat_o      = stat_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_y86_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_y86_mem_stage
//  Purpose  : Directed self-checking bench for y86_mem_stage with a
//             behavioural data memory and a queue of expected results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_y86_mem_stage;

    localparam logic [63:0] MEM = 64'h10000;
    localparam int          TO  = 255;

    localparam logic [3:0] SAOK = 4'd1, SHLT = 4'd2, SADR = 4'd3, SINS = 4'd4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  icode_i;
    logic [63:0] valE_i, valA_i, valP_i;
    logic        busy_o, done_o;
    logic [63:0] valM_o;
    logic [3:0]  stat_o;
    logic        mem_req_o, mem_we_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic        mem_ready_i;
    logic [63:0] mem_rdata_i;
    logic        mem_err_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] valM;
        logic [3:0]  stat;
        int          lat;
        int          reqc;
    } exp_t;

    exp_t exp_q[$];

    y86_mem_stage dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .icode_i     (icode_i),
        .valE_i      (valE_i),
        .valA_i      (valA_i),
        .valP_i      (valP_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .valM_o      (valM_o),
        .stat_o      (stat_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_err_i   (mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue one instruction at a negedge, act as memory, and compare at done_o.
    task automatic run_op(
        input string       name,
        input logic [3:0]  ic,
        input logic [63:0] e, input logic [63:0] a, input logic [63:0] p,
        input int          wait_n,
        input logic        err,
        input logic [63:0] rdata,
        input logic        exp_we,
        input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
        input logic [63:0] exp_valM, input logic [3:0] exp_stat,
        input int          exp_lat, input int exp_reqc,
        input bit          pulse
    );
        exp_t x;
        int   k;
        int   reqc;
        bit   seen_done;
        x.valM = exp_valM; x.stat = exp_stat; x.lat = exp_lat; x.reqc = exp_reqc;
        exp_q.push_back(x);
        start_i = 1'b1; icode_i = ic; valE_i = e; valA_i = a; valP_i = p;
        @(negedge clk_i);
        k = 1; reqc = 0; seen_done = 0;
        while (!seen_done && k <= 600) begin
            start_i = 1'b0;
            valE_i  = {$urandom, $urandom};
            valA_i  = {$urandom, $urandom};
            valP_i  = {$urandom, $urandom};
            if (mem_req_o) begin
                reqc++;
                check({name, ".we"},    {63'd0, mem_we_o}, {63'd0, exp_we});
                check({name, ".addr"},  mem_addr_o, exp_addr);
                if (exp_we)
                    check({name, ".wdata"}, mem_wdata_o, exp_wdata);
                mem_ready_i = (reqc == wait_n + 1);
                mem_err_i   = err && mem_ready_i;
                mem_rdata_i = mem_ready_i ? rdata : {$urandom, $urandom};
                if (pulse && reqc == 1) begin
                    start_i = 1'b1;
                    icode_i = 4'h0;
                end
            end else begin
                mem_ready_i = 1'b0;
                mem_err_i   = 1'b0;
                mem_rdata_i = {$urandom, $urandom};
            end
            if (done_o) begin
                seen_done = 1;
                x = exp_q.pop_front();
                check({name, ".valM"}, valM_o, x.valM);
                check({name, ".stat"}, {60'd0, stat_o}, {60'd0, x.stat});
                check({name, ".lat"},  64'(k + 1), 64'(x.lat));
                check({name, ".reqc"}, 64'(reqc), 64'(x.reqc));
            end else begin
                @(negedge clk_i);
                k++;
            end
        end
        if (!seen_done) begin
            checks++;
            failures++;
            $error("FAIL %s.done_timeout observed=no_done expected=done", name);
            void'(exp_q.pop_front());
        end
        mem_ready_i = 1'b0;
        mem_err_i   = 1'b0;
        @(negedge clk_i);
        check({name, ".done_clr"}, {63'd0, done_o}, 64'd0);
        check({name, ".idle"},     {63'd0, busy_o}, 64'd0);
        if (pulse) begin
            // A start seen during REQ must not have been queued
            for (int i = 0; i < 3; i++) begin
                @(negedge clk_i);
                check({name, ".no_extra_done"}, {62'd0, done_o, busy_o}, 64'd0);
            end
        end
    endtask

    initial begin
        int extra;
        rst_i = 1'b1; start_i = 1'b0; icode_i = 4'h1;
        valE_i = 64'd0; valA_i = 64'd0; valP_i = 64'd0;
        mem_ready_i = 1'b0; mem_rdata_i = 64'd0; mem_err_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst.busy",  {63'd0, busy_o},    64'd0);
        check("rst.done",  {63'd0, done_o},    64'd0);
        check("rst.req",   {63'd0, mem_req_o}, 64'd0);
        check("rst.we",    {63'd0, mem_we_o},  64'd0);
        check("rst.addr",  mem_addr_o,         64'd0);
        check("rst.wdata", mem_wdata_o,        64'd0);
        check("rst.valM",  valM_o,             64'd0);
        check("rst.stat",  {60'd0, stat_o},    64'(SAOK));
        rst_i = 1'b0;
        @(negedge clk_i);

        //      name      icode  valE                    valA         valP     wait err rdata          we   addr          wdata     valM           stat lat    reqc pulse
        run_op("mrmov",   4'h5, 64'h100,                64'h0,       64'h0,   2,   0, 64'hDEADBEEF, 0, 64'h100,      64'h0,    64'hDEADBEEF,  SAOK, 5,     3,   0);
        run_op("call",    4'h8, 64'h1F8,                64'h77,      64'h40,  0,   0, 64'h0,        1, 64'h1F8,      64'h40,   64'h0,         SAOK, 3,     1,   0);
        run_op("popbad",  4'hB, 64'h0,                  MEM - 64'd4, 64'h0,   0,   0, 64'h0,        0, 64'h0,        64'h0,    64'h0,         SADR, 2,     0,   0);
        run_op("rmwrap",  4'h4, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5,      64'h0,   0,   0, 64'h0,        1, 64'h0,        64'h0,    64'h0,         SADR, 2,     0,   0);
        run_op("opq",     4'h6, 64'h123,                64'h0,       64'h0,   0,   0, 64'h0,        0, 64'h0,        64'h0,    64'h0,         SAOK, 2,     0,   0);
        run_op("halt",    4'h0, 64'h0,                  64'h0,       64'h0,   0,   0, 64'h0,        0, 64'h0,        64'h0,    64'h0,         SHLT, 2,     0,   0);
        run_op("insC",    4'hC, 64'h10,                 64'h10,      64'h0,   0,   0, 64'h0,        0, 64'h0,        64'h0,    64'h0,         SINS, 2,     0,   0);
        run_op("mrlast",  4'h5, MEM - 64'd8,            64'h0,       64'h0,   1,   0, 64'h0123_4567_89AB_CDEF, 0, MEM - 64'd8, 64'h0, 64'h0123_4567_89AB_CDEF, SAOK, 4, 2, 0);
        run_op("push",    4'hA, 64'h300,                64'hA5A5,    64'h0,   1,   0, 64'hFFFF,     1, 64'h300,      64'hA5A5, 64'h0,         SAOK, 4,     2,   0);
        run_op("popedge", 4'hB, 64'h0,                  MEM - 64'd7, 64'h0,   0,   0, 64'h0,        0, 64'h0,        64'h0,    64'h0,         SADR, 2,     0,   0);
        run_op("retok",   4'h9, 64'h999,                64'h200,     64'h0,   0,   0, 64'h7777,     0, 64'h200,      64'h0,    64'h7777,      SAOK, 3,     1,   0);
        run_op("timeout", 4'h5, 64'h80,                 64'h0,       64'h0,   1000, 0, 64'h0,       0, 64'h80,       64'h0,    64'h0,         SADR, TO + 2, TO, 0);
        run_op("tie",     4'h5, 64'h88,                 64'h0,       64'h0,   TO - 1, 0, 64'h55,    0, 64'h88,       64'h0,    64'h55,        SAOK, TO + 2, TO, 0);
        run_op("buserr",  4'h9, 64'h0,                  64'h208,     64'h0,   1,   1, 64'hBAD0,     0, 64'h208,      64'h0,    64'h0,         SADR, 4,     2,   0);
        run_op("pulse",   4'h5, 64'h400,                64'h0,       64'h0,   3,   0, 64'h4242,     0, 64'h400,      64'h0,    64'h4242,      SAOK, 6,     4,   1);

        // Asynchronous reset in the middle of a request
        start_i = 1'b1; icode_i = 4'h5; valE_i = 64'h480;
        @(negedge clk_i);
        start_i = 1'b0;
        check("rstreq.req_before", {63'd0, mem_req_o}, 64'd1);
        #2 rst_i = 1'b1;
        #1;
        check("rstreq.req_dropped", {63'd0, mem_req_o}, 64'd0);
        check("rstreq.busy",        {63'd0, busy_o},    64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (done_o || mem_req_o) extra++;
        end
        check("rstreq.no_done", 64'(extra), 64'd0);

        // Recovery after reset
        run_op("recover", 4'h5, 64'h500, 64'h0, 64'h0, 0, 0, 64'hCAFE, 0, 64'h500, 64'h0, 64'hCAFE, SAOK, 3, 1, 0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/y86_mem_stage.md
# y86_mem_stage

Memory-access stage of the Y86-64 datapath: the consumer of the execute stage's `valE` result. It accepts one instruction at a time from execute, decides whether a load, store or no access is needed, and drives a valid/ready data-memory bus. It returns `valM` and the instruction status to writeback with a one-cycle `done_o` pulse. A multi-cycle FSM with a timeout makes it tolerant of slow or faulty memories.

## Interface
- `MEM_SIZE`, 64'h10000: bytes of legal data address space; an access needs `addr + 8 <= MEM_SIZE`.
- `TIMEOUT_CYCLES`, 255: maximum cycles a request may wait for `mem_ready_i`.
- `clk_i`  in  1  clock, all state on rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `start_i`  in  1  instruction valid from execute; honoured only when `busy_o`=0
- `icode_i`  in  4  instruction code (`define.v` encodings)
- `valE_i`  in  64  ALU result from execute
- `valA_i`  in  64  register A value
- `valP_i`  in  64  next-PC value (return address for call)
- `busy_o`  out  1  stage occupied; `start_i` ignored
- `done_o`  out  1  one-cycle pulse; `valM_o`/`stat_o` valid
- `valM_o`  out  64  loaded data (0 for non-loads)
- `stat_o`  out  4  `SAOK`=1, `SHLT`=2, `SADR`=3, `SINS`=4
- `mem_req_o`  out  1  memory request valid
- `mem_we_o`  out  1  1 = write, 0 = read
- `mem_addr_o`  out  64  byte address
- `mem_wdata_o`  out  64  write data
- `mem_ready_i`  in  1  memory accepts/completes the request this cycle
- `mem_rdata_i`  in  64  read data, valid when `mem_ready_i`=1
- `mem_err_i`  in  1  bus error, sampled with `mem_ready_i`

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: `busy_o`=0. On `start_i`=1, latch all inputs, classify, and set `busy_o`=1.
- Classification by icode:
  - write `valA` to `valE`: `IRMMOVQ`, `IPUSHQ`
  - write `valP` to `valE`: `ICALL`
  - read from `valE`: `IMRMOVQ`
  - read from `valA`: `IPOPQ`, `IRET`
  - no access, `SAOK`: `INOP`, `ICMOVQ`, `IIRMOVQ`, `IOPQ`, `IJXX`
  - no access, `SHLT`: `IHALT`
  - no access, `SINS`: icode > 4'hB
- Range check at latch: if an access is needed and `addr > MEM_SIZE-8`, use unsigned compare, and `addr >= 2^64-8` also fails (no wrap). A failing access goes straight to DONE with `SADR` and no request is issued.
- No-access instructions go IDLE -> DONE.
- Legal accesses go IDLE -> REQ.
- REQ:
  - `mem_req_o`=1, with `mem_addr_o`, `mem_we_o` and `mem_wdata_o` held stable.
  - On `mem_ready_i`=1: capture `mem_rdata_i` into `valM` (reads only); stat = `SADR` if `mem_err_i`, else `SAOK`; go to DONE.
  - A wait counter increments each REQ cycle without ready. When it reaches `TIMEOUT_CYCLES`: drop the request, stat = `SADR`, `valM`=0, go to DONE.
- DONE: `done_o`=1 for exactly one cycle, `busy_o`=1, then IDLE. Outputs `valM_o`/`stat_o` hold their values until the next DONE.
- `valM_o`=0 for writes, no-access instructions and errors.
- `start_i` in REQ or DONE is ignored; it is not queued.

## Timing
- Reset (async, immediate): state IDLE, `busy_o`=0, `done_o`=0, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `valM_o`=0, `stat_o`=`SAOK`, wait counter 0.
- Reset mid-REQ drops `mem_req_o` in the same cycle. The in-flight transaction is abandoned and `done_o` is not produced.
- Latency, start to `done_o`:
  - no access or range error: 2 cycles (start at edge N, DONE state after N+1, `done_o` high in that cycle)
  - memory access with ready in the first REQ cycle: 3 cycles
  - each wait cycle adds 1
  - timeout: `TIMEOUT_CYCLES`+2
- `mem_req_o` is registered; it never depends combinationally on `mem_ready_i`.
- Back-to-back: a new `start_i` may be accepted in the cycle after `done_o`.
- Ready arriving in the same cycle the counter hits `TIMEOUT_CYCLES`: ready wins, giving a normal completion.

## Test plan
- `IMRMOVQ`, valE=0x100, memory returns 0xDEADBEEF after 2 wait cycles -> one read at 0x100 with `mem_we_o`=0, then `done_o` with valM=0xDEADBEEF and `SAOK`; total latency 5 cycles.
- `ICALL`, valE=0x1F8, valP=0x40, ready immediate -> write of 0x40 to 0x1F8; `done_o` at cycle 3 with valM=0 and `SAOK`.
- `IPOPQ`, valA=MEM_SIZE-4 -> no `mem_req_o`; `done_o` at cycle 2 with `SADR`. Also `IRMMOVQ` at 64'hFFFF_FFFF_FFFF_FFFC -> `SADR` (no wrap).
- `IOPQ` -> `SAOK` at 2 cycles; `IHALT` -> `SHLT`; icode 4'hC -> `SINS`. None assert `mem_req_o`.
- `mem_ready_i` held 0 -> `mem_req_o` drops after exactly `TIMEOUT_CYCLES` cycles and `stat_o`=`SADR`. Separately, `mem_err_i`=1 with ready -> `SADR`.
- Assert `rst_i` during REQ -> `mem_req_o`=0 before the next edge and no `done_o`. A `start_i` pulse during REQ -> ignored, so only one `done_o` is produced.
